// File: rtl/tile_pkg.sv
// Shared types, tile patterns and palettes for the tile renderer.
// Imported by the map RAM and the renderer top.
package tile_pkg;

    localparam int MAP_COLS   = 80;
    localparam int MAP_ROWS   = 60;
    localparam int MAP_DEPTH  = MAP_COLS * MAP_ROWS;
    localparam int TILE_SHIFT = 3;
    localparam int PIPE_LAT   = 3;

    typedef logic [3:0]  tile_t;
    typedef logic [12:0] map_addr_t;
    typedef logic [23:0] rgb_t;

    typedef enum logic {
        CLEAR,
        IDLE
    } rend_state_t;

    typedef struct packed {
        logic [2:0] xsub;
        logic [2:0] ysub;
        logic       hs;
        logic       vs;
        logic       bl;
    } s1_t;

    typedef struct packed {
        tile_t tile;
        logic  pbit;
        logic  hs;
        logic  vs;
        logic  bl;
    } s2_t;

    localparam s1_t S1_RST = '{xsub: 3'd0, ysub: 3'd0,
                               hs: 1'b1, vs: 1'b1, bl: 1'b0};
    localparam s2_t S2_RST = '{tile: 4'd0, pbit: 1'b0,
                               hs: 1'b1, vs: 1'b1, bl: 1'b0};

    // Row 0 is the top line of a tile; bit 7 is its leftmost pixel.
    localparam logic [0:15][0:7][7:0] PATTERN = '{
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
        '{8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55},
        '{8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF},
        '{8'h00, 8'h7E, 8'h42, 8'h42, 8'h42, 8'h42, 8'h7E, 8'h00},
        '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'h7E, 8'h3C, 8'h18},
        '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'h0F, 8'h0F, 8'h0F, 8'h0F},
        '{8'h81, 8'h42, 8'h24, 8'h18, 8'h18, 8'h24, 8'h42, 8'h81},
        '{8'h18, 8'h18, 8'h18, 8'hFF, 8'hFF, 8'h18, 8'h18, 8'h18},
        '{8'h3C, 8'h42, 8'h81, 8'h81, 8'h81, 8'h81, 8'h42, 8'h3C},
        '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00},
        '{8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24, 8'h24},
        '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80},
        '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01},
        '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00},
        '{8'h66, 8'h99, 8'h99, 8'h66, 8'h66, 8'h99, 8'h99, 8'h66}
    };

    localparam logic [0:1][0:15][23:0] FG = '{
        '{24'h000000, 24'hFFFFFF, 24'hFF0000, 24'h00FF00,
          24'h0000FF, 24'hFFFF00, 24'h00FFFF, 24'hFF00FF,
          24'h808080, 24'hC0C0C0, 24'h800000, 24'h008000,
          24'h000080, 24'h808000, 24'h008080, 24'h800080},
        '{24'h101010, 24'hF0F0F0, 24'hF08080, 24'h80F080,
          24'h8080F0, 24'hF0F080, 24'h80F0F0, 24'hF080F0,
          24'h404040, 24'hA0A0A0, 24'h602020, 24'h206020,
          24'h202060, 24'h606020, 24'h206060, 24'h602060}
    };

    localparam logic [0:1][23:0] BG = '{24'h000040, 24'h202020};

    // row*80 + col as two shifts and adds
    function automatic map_addr_t map_addr(input logic [6:0] col,
                                           input logic [5:0] row);
        return map_addr_t'({row, 6'b0})
             + map_addr_t'({row, 4'b0})
             + map_addr_t'(col);
    endfunction

endpackage

// File: rtl/tile_map_ram.sv
// 4800x4 tile map: one write port, one registered read port.
// A read and write to the same address in one clk returns the old tile.
module tile_map_ram
    import tile_pkg::*;
(
    input  logic      clk,
    input  logic      we,
    input  map_addr_t waddr,
    input  tile_t     wdata,
    input  logic      re,
    input  map_addr_t raddr,
    output tile_t     rdata
);

    tile_t mem [MAP_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tile_renderer.sv
// Tile-map pixel colour stage: map lookup, pattern bit, palette,
// with sync and blank carried alongside so the DAC stays aligned.
module tile_renderer
    import tile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       hsync_i,
    input  logic       vsync_i,
    input  logic       blank_b_i,
    input  logic       theme,
    input  logic       wr_en,
    input  logic [6:0] wr_col,
    input  logic [5:0] wr_row,
    input  logic [3:0] wr_tile,
    input  logic       clr_req,
    output logic       busy,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       blank_b_o,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    rend_state_t state_q, state_d;
    map_addr_t   cnt_q, cnt_d;

    logic      ram_we;
    map_addr_t ram_waddr;
    tile_t     ram_wdata;
    tile_t     rd_tile;
    map_addr_t rd_addr;
    map_addr_t wr_addr;
    logic      wr_ok;
    logic      in_range;

    s1_t  s1_q;
    s2_t  s2_q;
    rgb_t rgb_q;
    rgb_t colour;
    logic hs_q, vs_q, bl_q;
    logic pbit;

    assign in_range = (x < 10'd640) && (y < 10'd480);
    assign rd_addr  = in_range
                    ? map_addr(7'(x >> TILE_SHIFT), 6'(y >> TILE_SHIFT))
                    : '0;

    assign wr_addr = map_addr(wr_col, wr_row);
    assign wr_ok   = wr_en
                   && (wr_col < 7'(MAP_COLS))
                   && (wr_row < 6'(MAP_ROWS));

    assign busy = (state_q == CLEAR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The clear sweep owns the write port; game writes are dropped.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_waddr = wr_addr;
        ram_wdata = wr_tile;
        unique case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = '0;
                if (cnt_q == map_addr_t'(MAP_DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            IDLE: begin
                ram_we = wr_ok;
                if (clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    tile_map_ram u_map (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (pix_en),
        .raddr (rd_addr),
        .rdata (rd_tile)
    );

    assign pbit   = PATTERN[rd_tile][s1_q.ysub][3'd7 - s1_q.xsub];
    assign colour = s2_q.pbit ? FG[theme][s2_q.tile] : BG[theme];

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q  <= S1_RST;
            s2_q  <= S2_RST;
            rgb_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            bl_q  <= 1'b0;
        end else if (pix_en) begin
            s1_q.xsub <= x[2:0];
            s1_q.ysub <= y[2:0];
            s1_q.hs   <= hsync_i;
            s1_q.vs   <= vsync_i;
            s1_q.bl   <= blank_b_i && in_range;

            s2_q.tile <= rd_tile;
            s2_q.pbit <= pbit;
            s2_q.hs   <= s1_q.hs;
            s2_q.vs   <= s1_q.vs;
            s2_q.bl   <= s1_q.bl;

            rgb_q <= s2_q.bl ? colour : '0;
            hs_q  <= s2_q.hs;
            vs_q  <= s2_q.vs;
            bl_q  <= s2_q.bl;
        end
    end

    assign r         = rgb_q[23:16];
    assign g         = rgb_q[15:8];
    assign b         = rgb_q[7:0];
    assign hsync_o   = hs_q;
    assign vsync_o   = vs_q;
    assign blank_b_o = bl_q;

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer: table vectors, clear sequences and a
// tile-map reference model driven with random pixels and writes.
module tb_tile_renderer;
    import tile_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_en;
    logic [9:0] x, y;
    logic       hsync_i, vsync_i, blank_b_i;
    logic       theme;
    logic       wr_en;
    logic [6:0] wr_col;
    logic [5:0] wr_row;
    logic [3:0] wr_tile;
    logic       clr_req;
    logic       busy;
    logic       hsync_o, vsync_o, blank_b_o;
    logic [7:0] r, g, b;

    tile_renderer dut (
        .clk       (clk),
        .rst       (rst),
        .pix_en    (pix_en),
        .x         (x),
        .y         (y),
        .hsync_i   (hsync_i),
        .vsync_i   (vsync_i),
        .blank_b_i (blank_b_i),
        .theme     (theme),
        .wr_en     (wr_en),
        .wr_col    (wr_col),
        .wr_row    (wr_row),
        .wr_tile   (wr_tile),
        .clr_req   (clr_req),
        .busy      (busy),
        .hsync_o   (hsync_o),
        .vsync_o   (vsync_o),
        .blank_b_o (blank_b_o),
        .r         (r),
        .g         (g),
        .b         (b)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        bl;
    } exp_t;

    typedef struct {
        int          px;
        int          py;
        logic        bl;
        logic        exp_bl;
        logic [23:0] rgb;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    logic [3:0] mmap [4800];
    exp_t pend [$];
    exp_t last_exp;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    function automatic exp_t model_exp(int px, int py, logic hs,
                                       logic vs, logic bl);
        exp_t e;
        logic [7:0] row;
        int t;
        e.hs  = hs;
        e.vs  = vs;
        e.bl  = bl && (px < 640) && (py < 480);
        e.rgb = 24'h0;
        if (e.bl) begin
            t     = int'(mmap[(py / 8) * 80 + px / 8]);
            row   = PATTERN[t][py % 8];
            e.rgb = row[7 - px % 8] ? FG[theme][t] : BG[theme];
        end
        return e;
    endfunction

    function automatic void model_write(int c, int rw, logic [3:0] t);
        if (c < 80 && rw < 60) mmap[rw * 80 + c] = t;
    endfunction

    // One pixel strobe (two clks), optionally with a map write on the
    // strobe clk; checks the result of the strobe PIPE_LAT-1 earlier.
    task automatic drive_strobe(input int px, input int py,
                                input logic hs, input logic vs,
                                input logic bl, input logic we,
                                input int wc, input int wrw,
                                input logic [3:0] wt, input exp_t e);
        exp_t f;
        x = 10'(px); y = 10'(py);
        hsync_i = hs; vsync_i = vs; blank_b_i = bl;
        pix_en = 1'b1;
        wr_en = we; wr_col = 7'(wc); wr_row = 6'(wrw); wr_tile = wt;
        @(posedge clk);
        @(negedge clk);
        pix_en = 1'b0;
        wr_en = 1'b0;
        if (we) model_write(wc, wrw, wt);
        pend.push_back(e);
        if (pend.size() == PIPE_LAT) begin
            f = pend.pop_front();
            chk("pixel", {5'd0, r, g, b, hsync_o, vsync_o, blank_b_o},
                {5'd0, f.rgb, f.hs, f.vs, f.bl});
            last_exp = f;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic mstrobe(input int px, input int py, input logic hs,
                           input logic vs, input logic bl);
        drive_strobe(px, py, hs, vs, bl, 1'b0, 0, 0, 4'd0,
                     model_exp(px, py, hs, vs, bl));
    endtask

    task automatic flush();
        for (int i = 0; i < PIPE_LAT; i++) mstrobe(0, 0, 1, 1, 0);
    endtask

    task automatic wr(input int c, input int rw, input logic [3:0] t);
        wr_en = 1'b1; wr_col = 7'(c); wr_row = 6'(rw); wr_tile = t;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        model_write(c, rw, t);
    endtask

    // Counts clks with busy high; optional write and clr_req inside.
    task automatic count_busy(input logic extras, output int n);
        n = 0;
        while (busy === 1'b1 && n < 6000) begin
            n++;
            if (extras && n == 100) begin
                wr_en = 1'b1; wr_col = 7'd0; wr_row = 6'd0;
                wr_tile = 4'd1;
            end
            if (extras && n == 2000) clr_req = 1'b1;
            @(posedge clk);
            @(negedge clk);
            wr_en = 1'b0;
            clr_req = 1'b0;
        end
    endtask

    exp_t e;
    int   n;

    initial begin
        tbl[0]  = '{16,  8,   1, 1, 24'h000040};
        tbl[1]  = '{19,  8,   1, 1, 24'hFFFF00};
        tbl[2]  = '{20,  8,   1, 1, 24'hFFFF00};
        tbl[3]  = '{21,  8,   1, 1, 24'h000040};
        tbl[4]  = '{16,  11,  1, 1, 24'hFFFF00};
        tbl[5]  = '{23,  12,  1, 1, 24'hFFFF00};
        tbl[6]  = '{17,  9,   1, 1, 24'h000040};
        tbl[7]  = '{18,  9,   1, 1, 24'hFFFF00};
        tbl[8]  = '{24,  8,   1, 1, 24'h000040};
        tbl[9]  = '{15,  8,   1, 1, 24'h000040};
        tbl[10] = '{16,  16,  1, 1, 24'h000040};
        tbl[11] = '{23,  15,  1, 1, 24'h000040};
        tbl[12] = '{19,  15,  1, 1, 24'hFFFF00};
        tbl[13] = '{20,  10,  0, 0, 24'h000000};
        tbl[14] = '{700, 8,   1, 0, 24'h000000};
        tbl[15] = '{16,  480, 1, 0, 24'h000000};

        rst = 1'b0; pix_en = 1'b0; x = '0; y = '0;
        hsync_i = 1'b1; vsync_i = 1'b1; blank_b_i = 1'b0;
        theme = 1'b0; wr_en = 1'b0; wr_col = '0; wr_row = '0;
        wr_tile = '0; clr_req = 1'b0;
        for (int i = 0; i < 4800; i++) mmap[i] = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rgb", {8'd0, r, g, b}, 32'd0);
        chk("reset_hsync", {31'd0, hsync_o}, 32'd1);
        chk("reset_vsync", {31'd0, vsync_o}, 32'd1);
        chk("reset_blank", {31'd0, blank_b_o}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd1);

        rst = 1'b1;
        count_busy(1'b0, n);
        chk("init_clear_len", 32'(n), 32'd4800);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 40; i++)
            mstrobe($urandom_range(639), $urandom_range(479), 1, 1, 1);

        wr(2, 1, 4'd5);
        foreach (tbl[i]) begin
            e = '{tbl[i].rgb, 1'b1, 1'b1, tbl[i].exp_bl};
            drive_strobe(tbl[i].px, tbl[i].py, 1, 1, tbl[i].bl,
                         1'b0, 0, 0, 4'd0, e);
        end

        mstrobe(19, 8, 0, 1, 1);
        mstrobe(20, 8, 1, 0, 1);
        mstrobe(21, 8, 0, 0, 0);
        mstrobe(22, 8, 1, 1, 1);
        mstrobe(19, 11, 0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            x = 10'($urandom); y = 10'($urandom);
            hsync_i = 1'($urandom); vsync_i = 1'($urandom);
            blank_b_i = 1'($urandom);
        end
        chk("freeze", {5'd0, r, g, b, hsync_o, vsync_o, blank_b_o},
            {5'd0, last_exp.rgb, last_exp.hs, last_exp.vs,
             last_exp.bl});
        flush();

        wr(80, 0, 4'd3);
        wr(127, 0, 4'd3);
        wr(0, 60, 4'd3);
        wr(79, 63, 4'd3);
        e = '{24'h000040, 1'b1, 1'b1, 1'b1};
        drive_strobe(0, 8, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);
        drive_strobe(376, 8, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);
        drive_strobe(1, 8, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);
        flush();

        wr(9, 9, 4'd1);
        for (int i = 0; i < 20; i++)
            mstrobe($urandom_range(639), $urandom_range(479), 1, 1, 1);
        clr_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_req = 1'b0;
        count_busy(1'b1, n);
        chk("clr_len", 32'(n), 32'd4800);
        for (int i = 0; i < 4800; i++) mmap[i] = 4'd0;
        e = '{24'h000040, 1'b1, 1'b1, 1'b1};
        drive_strobe(0, 0, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);
        drive_strobe(19, 8, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);
        drive_strobe(72, 72, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);
        flush();

        e = '{24'h000040, 1'b1, 1'b1, 1'b1};
        drive_strobe(32, 16, 1, 1, 1, 1'b1, 4, 2, 4'd7, e);
        flush();
        e = '{24'hFF00FF, 1'b1, 1'b1, 1'b1};
        drive_strobe(32, 16, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);
        flush();

        wr(2, 1, 4'd5);
        theme = 1'b1;
        e = '{24'hF0F080, 1'b1, 1'b1, 1'b1};
        drive_strobe(19, 8, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);
        e = '{24'h202020, 1'b1, 1'b1, 1'b1};
        drive_strobe(16, 8, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);
        e = '{24'hF080F0, 1'b1, 1'b1, 1'b1};
        drive_strobe(39, 23, 1, 1, 1, 1'b0, 0, 0, 4'd0, e);

        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 150; i++) begin
                int px, py, wc, wrw;
                logic hs, vs, bl, we;
                logic [3:0] wt;
                px  = ($urandom_range(7) == 0) ? $urandom_range(799)
                                               : $urandom_range(79);
                py  = ($urandom_range(7) == 0) ? $urandom_range(524)
                                               : $urandom_range(39);
                hs  = ($urandom_range(7) != 0);
                vs  = ($urandom_range(7) != 0);
                bl  = ($urandom_range(5) != 0);
                we  = ($urandom_range(2) == 0);
                wc  = ($urandom_range(3) == 0) ? $urandom_range(127)
                                               : $urandom_range(9);
                wrw = ($urandom_range(3) == 0) ? $urandom_range(63)
                                               : $urandom_range(4);
                wt  = 4'($urandom);
                e = model_exp(px, py, hs, vs, bl);
                drive_strobe(px, py, hs, vs, bl, we, wc, wrw, wt, e);
            end
            flush();
            theme = ~theme;
        end
        chk("end_busy", {31'd0, busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
